// File: rtl/test_seq_pkg.sv
// Shared types for the FPGA test-run sequencer.
// States, run results and counter widths.
package test_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RESET_HOLD,
    BOOT,
    RUN,
    DONE
  } seq_state_e;

  typedef enum logic [1:0] {
    RES_NONE,
    RES_PASS,
    RES_FAIL,
    RES_TIMEOUT
  } run_result_e;

  localparam int unsigned RUN_COUNT_W = 8;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchroniser followed by a registered rising-edge pulse.
// Pulse appears three clocks after the input edge, one cycle wide.
module sync_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic pulse_o
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;
  logic pulse_q, pulse_d;

  always_comb begin
    meta_d  = d_i;
    sync_d  = meta_q;
    prev_d  = sync_q;
    pulse_d = sync_q & ~prev_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      meta_q  <= meta_d;
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/test_run_sequencer.sv
// Sequences one bare-metal core test run: reset hold, boot, run,
// then latches pass/fail/timeout until the start button re-arms it.
module test_run_sequencer
  import test_seq_pkg::*;
#(
  parameter int unsigned RESET_HOLD_CYCLES = 16,
  parameter int unsigned TIMEOUT_CYCLES    = 2**24,
  parameter int unsigned CNT_WIDTH         = 32,
  parameter bit          AUTO_START        = 1'b0
) (
  input  logic                   s_axi_aclk,
  input  logic                   s_axi_aresetn,
  input  logic                   start_i,
  input  logic                   exit_valid_i,
  input  logic                   exit_zero_i,
  output logic                   core_rst_no,
  output logic                   periph_rst_no,
  output logic                   fetch_enable_o,
  output logic                   busy_o,
  output logic                   pass_o,
  output logic                   fail_o,
  output logic                   timeout_o,
  output logic [CNT_WIDTH-1:0]   cycle_count_o,
  output logic [RUN_COUNT_W-1:0] run_count_o
);

  localparam int unsigned HOLD_W =
    $clog2(RESET_HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST =
    HOLD_W'(RESET_HOLD_CYCLES - 1);
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_WIDTH-1:0] TO_LAST =
    CNT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam seq_state_e RST_STATE =
    AUTO_START ? RESET_HOLD : IDLE;

  logic start_pulse;

  sync_edge_det u_start_sync (
    .clk     (s_axi_aclk),
    .rst_n   (s_axi_aresetn),
    .d_i     (start_i),
    .pulse_o (start_pulse)
  );

  seq_state_e             state_q, state_d;
  run_result_e            res_q, res_d;
  logic [HOLD_W-1:0]      hold_q, hold_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [RUN_COUNT_W-1:0] runs_q, runs_d;

  logic core_rst_no_q, core_rst_no_d;
  logic periph_rst_no_q, periph_rst_no_d;
  logic fetch_q, fetch_d;
  logic busy_q, busy_d;
  logic pass_q, pass_d;
  logic fail_q, fail_d;
  logic timeout_q, timeout_d;

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q;
    runs_d  = runs_q;

    unique case (state_q)
      IDLE: begin
        if (start_pulse) state_d = RESET_HOLD;
      end
      RESET_HOLD: begin
        if (hold_q == HOLD_LAST) state_d = BOOT;
        else hold_d = hold_q + 1'b1;
      end
      BOOT: begin
        state_d = RUN;
      end
      RUN: begin
        if (start_pulse) begin
          state_d = RESET_HOLD;
        end else if (exit_valid_i) begin
          state_d = DONE;
          res_d   = exit_zero_i ? RES_PASS : RES_FAIL;
        end else if (TO_EN && cnt_q == TO_LAST) begin
          state_d = DONE;
          res_d   = RES_TIMEOUT;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (start_pulse) state_d = RESET_HOLD;
      end
      default: state_d = IDLE;
    endcase

    // A fresh run wipes everything the previous one left behind.
    if (state_d == RESET_HOLD && state_q != RESET_HOLD) begin
      hold_d = '0;
      cnt_d  = '0;
      res_d  = RES_NONE;
    end
    if (state_d == DONE && state_q != DONE) begin
      runs_d = runs_q + 1'b1;
    end
  end

  // Outputs are decoded from the next state so they leave a flop.
  always_comb begin
    core_rst_no_d   = state_d inside {BOOT, RUN};
    periph_rst_no_d = state_d inside {BOOT, RUN, DONE};
    fetch_d         = state_d == RUN;
    busy_d          = state_d inside {RESET_HOLD, BOOT, RUN};
    pass_d          = res_d == RES_PASS;
    fail_d          = res_d == RES_FAIL;
    timeout_d       = res_d == RES_TIMEOUT;
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state_q         <= RST_STATE;
      res_q           <= RES_NONE;
      hold_q          <= '0;
      cnt_q           <= '0;
      runs_q          <= '0;
      core_rst_no_q   <= 1'b0;
      periph_rst_no_q <= 1'b0;
      fetch_q         <= 1'b0;
      busy_q          <= 1'b0;
      pass_q          <= 1'b0;
      fail_q          <= 1'b0;
      timeout_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      res_q           <= res_d;
      hold_q          <= hold_d;
      cnt_q           <= cnt_d;
      runs_q          <= runs_d;
      core_rst_no_q   <= core_rst_no_d;
      periph_rst_no_q <= periph_rst_no_d;
      fetch_q         <= fetch_d;
      busy_q          <= busy_d;
      pass_q          <= pass_d;
      fail_q          <= fail_d;
      timeout_q       <= timeout_d;
    end
  end

  assign core_rst_no    = core_rst_no_q;
  assign periph_rst_no  = periph_rst_no_q;
  assign fetch_enable_o = fetch_q;
  assign busy_o         = busy_q;
  assign pass_o         = pass_q;
  assign fail_o         = fail_q;
  assign timeout_o      = timeout_q;
  assign cycle_count_o  = cnt_q;
  assign run_count_o    = runs_q;

endmodule

// File: tb/tb_test_run_sequencer.sv
// Bench for the test-run sequencer: manual-start and auto-start builds
// checked against a run-level model of expected results.
module tb_test_run_sequencer;

  localparam int HOLD_A = 16;
  localparam int TMO_A  = 1000;
  localparam int HOLD_B = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a_n, rst_b_n;
  logic start, ev, ez;
  logic sel_b;

  logic a_core, a_per, a_fetch, a_busy;
  logic a_pass, a_fail, a_tmo;
  logic [31:0] a_cnt;
  logic [7:0]  a_runs;
  logic b_core, b_per, b_fetch, b_busy;
  logic b_pass, b_fail, b_tmo;
  logic [31:0] b_cnt;
  logic [7:0]  b_runs;

  logic o_core, o_per, o_fetch, o_busy;
  logic o_pass, o_fail, o_tmo;
  logic [31:0] o_cnt;
  logic [7:0]  o_runs;

  test_run_sequencer #(
    .RESET_HOLD_CYCLES(HOLD_A),
    .TIMEOUT_CYCLES   (TMO_A),
    .CNT_WIDTH        (32),
    .AUTO_START       (1'b0)
  ) u_dut_a (
    .s_axi_aclk    (clk),
    .s_axi_aresetn (rst_a_n),
    .start_i       (start),
    .exit_valid_i  (ev),
    .exit_zero_i   (ez),
    .core_rst_no   (a_core),
    .periph_rst_no (a_per),
    .fetch_enable_o(a_fetch),
    .busy_o        (a_busy),
    .pass_o        (a_pass),
    .fail_o        (a_fail),
    .timeout_o     (a_tmo),
    .cycle_count_o (a_cnt),
    .run_count_o   (a_runs)
  );

  test_run_sequencer #(
    .RESET_HOLD_CYCLES(HOLD_B),
    .TIMEOUT_CYCLES   (0),
    .CNT_WIDTH        (32),
    .AUTO_START       (1'b1)
  ) u_dut_b (
    .s_axi_aclk    (clk),
    .s_axi_aresetn (rst_b_n),
    .start_i       (start),
    .exit_valid_i  (ev),
    .exit_zero_i   (ez),
    .core_rst_no   (b_core),
    .periph_rst_no (b_per),
    .fetch_enable_o(b_fetch),
    .busy_o        (b_busy),
    .pass_o        (b_pass),
    .fail_o        (b_fail),
    .timeout_o     (b_tmo),
    .cycle_count_o (b_cnt),
    .run_count_o   (b_runs)
  );

  always_comb begin
    o_core  = sel_b ? b_core  : a_core;
    o_per   = sel_b ? b_per   : a_per;
    o_fetch = sel_b ? b_fetch : a_fetch;
    o_busy  = sel_b ? b_busy  : a_busy;
    o_pass  = sel_b ? b_pass  : a_pass;
    o_fail  = sel_b ? b_fail  : a_fail;
    o_tmo   = sel_b ? b_tmo   : a_tmo;
    o_cnt   = sel_b ? b_cnt   : a_cnt;
    o_runs  = sel_b ? b_runs  : a_runs;
  end

  int checks   = 0;
  int failures = 0;
  int hold_n;
  int tmo;
  int exp_runs;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_core"}, o_core, 0);
    check({tag, "_per"},  o_per,  0);
    check({tag, "_fetch"}, o_fetch, 0);
    check({tag, "_busy"}, o_busy, 0);
    check({tag, "_pass"}, o_pass, 0);
    check({tag, "_fail"}, o_fail, 0);
    check({tag, "_tmo"},  o_tmo,  0);
    check({tag, "_cnt"},  o_cnt,  0);
    check({tag, "_runs"}, o_runs, 0);
  endtask

  // Button press: sync (3) + state register (1) = hold seen 4 negedges on.
  task automatic press_start();
    int lat = 0;
    bit seen = 0;
    start = 1'b1;
    while (!seen && lat < 10) begin
      @(negedge clk);
      lat++;
      if (lat == 2) start = 1'b0;
      if (o_busy && !o_core) seen = 1;
    end
    start = 1'b0;
    check("start_lat", lat, 4);
    check("hold_seen", seen, 1);
    check("hold_per", o_per, 0);
    check("hold_fetch", o_fetch, 0);
    check("hold_pass", o_pass, 0);
    check("hold_fail", o_fail, 0);
    check("hold_tmo", o_tmo, 0);
    check("hold_cnt", o_cnt, 0);
    check("hold_runs", o_runs, exp_runs % 256);
  endtask

  // Stale exit levels are driven through the hold and into boot.
  task automatic hold_boot();
    int low = 0;
    while (o_busy && !o_core && low < 64) begin
      low++;
      ev = 1'b1;
      ez = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    check("hold_len", low, hold_n);
    check("boot_core", o_core, 1);
    check("boot_per", o_per, 1);
    check("boot_fetch", o_fetch, 0);
    check("boot_busy", o_busy, 1);
  endtask

  task automatic run_to_done(input int e, input bit z);
    int k = 0;
    int lim;
    bit ex;
    int exp_cnt;
    ex = (tmo == 0) || (e < tmo);
    lim = ex ? e + 1 : tmo;
    exp_cnt = ex ? e : tmo - 1;
    @(negedge clk);
    check("run_fetch", o_fetch, 1);
    while (o_busy && k < lim + 4) begin
      check("run_cnt", o_cnt, k);
      ev = (k == e);
      if (k == e) ez = z;
      k++;
      @(negedge clk);
    end
    exp_runs++;
    check("run_len", k, lim);
    check("done_pass", o_pass, ex && z);
    check("done_fail", o_fail, ex && !z);
    check("done_tmo", o_tmo, !ex);
    check("done_cnt", o_cnt, exp_cnt);
    check("done_runs", o_runs, exp_runs % 256);
    check("done_core", o_core, 0);
    check("done_per", o_per, 1);
    check("done_fetch", o_fetch, 0);
    ev = 1'b1;
    ez = ~z;
    repeat (2) @(negedge clk);
    check("frz_pass", o_pass, ex && z);
    check("frz_fail", o_fail, ex && !z);
    check("frz_cnt", o_cnt, exp_cnt);
    check("frz_runs", o_runs, exp_runs % 256);
  endtask

  task automatic abort_run(input int a);
    @(negedge clk);
    ev = 1'b0;
    repeat (a) @(negedge clk);
    check("abort_fetch", o_fetch, 1);
    press_start();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1);
  end

  initial begin
    int k;
    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    start   = 1'b0;
    ev      = 1'b0;
    ez      = 1'b0;
    sel_b   = 1'b0;
    hold_n  = HOLD_A;
    tmo     = TMO_A;
    exp_runs = 0;

    repeat (2) @(negedge clk);
    check_zero("rstA");
    rst_a_n = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_busy", o_busy, 0);
    check("idle_core", o_core, 0);

    press_start(); hold_boot(); run_to_done(50, 1'b1);
    press_start(); hold_boot();
    run_to_done(int'($urandom_range(0, 300)), 1'b0);
    press_start(); hold_boot(); run_to_done(5000, 1'b1);
    press_start(); hold_boot();
    run_to_done(TMO_A - 1, 1'($urandom_range(0, 1)));
    press_start(); hold_boot();
    abort_run(int'($urandom_range(3, 200)));
    hold_boot();
    run_to_done(int'($urandom_range(0, 100)), 1'b1);

    for (int i = 0; i < 8; i++) begin
      press_start(); hold_boot();
      if ($urandom_range(0, 3) == 0) begin
        abort_run(int'($urandom_range(0, 400)));
        hold_boot();
      end
      run_to_done(int'($urandom_range(0, 1100)),
                  1'($urandom_range(0, 1)));
    end

    press_start(); hold_boot();
    ev = 1'b0;
    repeat (30) @(negedge clk);
    check("pre_rst_fetch", o_fetch, 1);
    #2;
    rst_a_n = 1'b0;
    #1;
    check_zero("asyncA");
    exp_runs = 0;
    @(negedge clk);
    rst_a_n = 1'b1;
    repeat (6) @(negedge clk);
    check("post_rst_busy", o_busy, 0);
    check("post_rst_runs", o_runs, 0);
    press_start(); hold_boot();
    run_to_done(int'($urandom_range(0, 40)), 1'b1);

    rst_a_n = 1'b0;
    sel_b   = 1'b1;
    hold_n  = HOLD_B;
    tmo     = 0;
    exp_runs = 0;
    ev = 1'b0;
    ez = 1'b0;
    #1;
    check_zero("rstB");
    @(negedge clk);
    rst_b_n = 1'b1;
    @(negedge clk);
    check("auto_busy", o_busy, 1);
    check("auto_core", o_core, 0);
    k = 1;
    while (!o_core && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("auto_boot_lat", k, HOLD_B);
    run_to_done(1500, 1'b1);

    for (int i = 1; i < 256; i++) begin
      press_start(); hold_boot();
      run_to_done(int'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)));
    end
    check("wrap_runs", o_runs, 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
